cache_controller: RTL and testbench
===================================

// Module: cache_controller
// PURPOSE
//  Write-back, write-allocate, 2-way set-associative cache with its controlling FSM.
//  Sits between the CPU request generator (read_write/address/write_data, advances on hit_miss)
//  and main memory (128-bit single-beat block bus with mem_ready handshake).
//  Owns the tag/valid/dirty/LRU state and the data array; sequences write-back and refill on a miss.
// PARAMETERS
//  ADDR_W   14  byte address width; tag width = ADDR_W-4-INDEX_W (8 at defaults)
//  INDEX_W  2   set index width (2**INDEX_W sets); block = 4 words = 16 bytes, fixed
// PORTS
//  clock           in   1        single clock, all state updates on posedge
//  reset           in   1        asynchronous, active-high
//  request         in   1        CPU request valid; CPU holds read_write/address/write_data until hit_miss
//  read_write      in   1        0=read word, 1=write word
//  address         in   ADDR_W   [1:0] ignored, [3:2] word, [3+INDEX_W:4] index, [ADDR_W-1:4+INDEX_W] tag
//  write_data      in   32       store data
//  hit_miss        out  1        1 = request completes this cycle (read_data valid / write commits at edge)
//  read_data       out  32       word read on completion; otherwise holds last value
//  mem_read        out  1        block refill request, held until mem_ready
//  mem_write       out  1        victim write-back request, held until mem_ready
//  mem_address     out  ADDR_W   block address, low 4 bits always 0
//  mem_write_data  out  128      victim block, word0 in [31:0]
//  mem_read_data   in   128      refill block, word0 in [31:0], sampled when mem_ready=1 in ALLOCATE
//  mem_ready       in   1        memory completes current transfer this cycle
// BEHAVIOUR
//  Reset (async): all valid, dirty, LRU bits =0; state=COMPARE; hit_miss=0, mem_read=0, mem_write=0,
//   mem_address=0, mem_write_data=0, read_data=0. Data array contents undefined.
//  FSM states: COMPARE, WRITE_BACK, ALLOCATE.
//  COMPARE: request=0 -> idle, hit_miss=0. request=1: hit = valid&&tag match in either way.
//   Hit: hit_miss=1 combinationally same cycle; read -> read_data=word (registered at edge, valid next
//   cycle too); write -> word written, dirty set at edge; LRU[set] <= ~hit_way. Stay COMPARE.
//   Miss: hit_miss=0; victim = way0 if invalid, else way1 if invalid, else LRU[set]; latch
//   address+victim. Victim valid&&dirty -> WRITE_BACK, else -> ALLOCATE.
//  WRITE_BACK: mem_write=1, mem_address={victim tag,index,4'b0}, mem_write_data=victim block;
//   on mem_ready -> ALLOCATE (mem_write low the following cycle).
//  ALLOCATE: mem_read=1, mem_address={latched tag,index,4'b0}; on mem_ready: fill victim way,
//   valid=1, dirty=0, tag updated -> COMPARE; request then hits (write-allocate: write merges on hit).
//  Latency: hit 1 cycle; clean miss = 1 + refill wait + 1; dirty miss adds write-back wait.
//  Never mem_read and mem_write together. mem_ready outside WRITE_BACK/ALLOCATE ignored.
//  hit_miss never asserted outside COMPARE. request dropped mid-miss: refill still completes.
//  reset mid-transfer: strobes drop immediately, arrays invalidated, transfer abandoned.
//  LRU: 1 bit per set = way to replace next; updated on every hit only (fill is followed by hit).
// TESTING
//  1 reset; read 0x0A4 -> mem_read=1, mem_address=0x0A0; mem_ready after 3 cycles with word1=0x11111111
//    -> ALLOCATE->COMPARE, hit_miss=1, read_data=0x11111111; no mem_write.
//  2 write 0x0A4 data 0xAABBCCDD -> hit_miss=1 first cycle, no mem strobe; read 0x0A0 word0 hit, 0x0A4 reads 0xAABBCCDD.
//  3 read 0x1A4 (tag 0x06, same set 2) -> fills way1 (invalid preferred), no write-back; LRU[2]=0.
//  4 read 0x2A4 (tag 0x0A) -> victim way0 dirty: mem_write, mem_address=0x0A0, mem_write_data[63:32]=0xAABBCCDD,
//    then mem_read at 0x2A0, then hit; subsequent 0x0A4 misses and evicts way1 (clean, no write).
//  5 reset pulse during WRITE_BACK -> mem_write=0 same cycle; after release read 0x1A4 misses (valid cleared).
//  6 request=0 with spurious mem_ready=1 for 5 cycles -> no strobes, hit_miss=0, state stays COMPARE.

Source files
------------

// File: rtl/cache_if.sv
// CPU-side and memory-side signal bundle for the 2-way write-back cache.
// Both sides use a hold-until-done handshake: the requester holds request/mem_read/mem_write
// with stable payload, and the transfer completes in the cycle hit_miss/mem_ready is 1.
interface cache_if #(
  parameter int ADDR_W = 14
);
  logic              request;
  logic              read_write;
  logic [ADDR_W-1:0] address;
  logic [31:0]       write_data;
  logic              hit_miss;
  logic [31:0]       read_data;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [127:0]      mem_write_data;
  logic [127:0]      mem_read_data;
  logic              mem_ready;

  modport master (
    output request, read_write, address, write_data, mem_read_data, mem_ready,
    input  hit_miss, read_data, mem_read, mem_write, mem_address, mem_write_data
  );

  modport slave (
    input  request, read_write, address, write_data, mem_read_data, mem_ready,
    output hit_miss, read_data, mem_read, mem_write, mem_address, mem_write_data
  );
endinterface

// File: rtl/cache_controller.sv
// Write-back, write-allocate, 2-way set-associative cache with its miss-handling FSM.
// Block = 4 words; memory moves whole blocks in one beat.
module cache_controller #(
  parameter int ADDR_W  = 14,
  parameter int INDEX_W = 2
) (
  input  logic       clock,
  input  logic       reset,
  cache_if.slave     bus,
  output logic [1:0] debug_state
);
  localparam int TAG_W = ADDR_W - 4 - INDEX_W;
  localparam int SETS  = 1 << INDEX_W;

  typedef enum logic [1:0] {
    COMPARE    = 2'd0,
    WRITE_BACK = 2'd1,
    ALLOCATE   = 2'd2
  } state_t;

  state_t state, state_next;

  logic [TAG_W-1:0]      tag_mem  [2][SETS];
  logic [127:0]          data_mem [2][SETS];
  logic [1:0][SETS-1:0]  valid;
  logic [1:0][SETS-1:0]  dirty;
  logic [SETS-1:0]       lru;

  logic [INDEX_W-1:0]    lat_idx;
  logic [TAG_W-1:0]      lat_tag;
  logic                  lat_way;

  logic [INDEX_W-1:0]    idx;
  logic [TAG_W-1:0]      tag;
  logic [1:0]            word;
  logic                  hit0, hit1, hit, hit_way, victim, victim_dirty;
  logic [31:0]           hit_word, read_q;
  logic                  hit_miss_c, mem_read_c, mem_write_c;
  logic [ADDR_W-1:0]     mem_address_c;
  logic [127:0]          mem_write_data_c;

  assign idx  = bus.address[3+INDEX_W:4];
  assign tag  = bus.address[ADDR_W-1:4+INDEX_W];
  assign word = bus.address[3:2];

  assign hit0    = valid[0][idx] && (tag_mem[0][idx] == tag);
  assign hit1    = valid[1][idx] && (tag_mem[1][idx] == tag);
  assign hit     = hit0 || hit1;
  assign hit_way = !hit0;
  assign hit_word = data_mem[hit_way][idx][{word, 5'd0} +: 32];

  // Invalid ways are filled first (way0 before way1); otherwise LRU picks the victim.
  assign victim       = !valid[0][idx] ? 1'b0 : (!valid[1][idx] ? 1'b1 : lru[idx]);
  assign victim_dirty = valid[victim][idx] && dirty[victim][idx];

  always_comb begin
    state_next       = state;
    hit_miss_c       = 1'b0;
    mem_read_c       = 1'b0;
    mem_write_c      = 1'b0;
    mem_address_c    = '0;
    mem_write_data_c = '0;
    case (state)
      COMPARE: begin
        if (bus.request) begin
          if (hit) hit_miss_c = 1'b1;
          else     state_next = victim_dirty ? WRITE_BACK : ALLOCATE;
        end
      end
      WRITE_BACK: begin
        mem_write_c      = 1'b1;
        mem_address_c    = {tag_mem[lat_way][lat_idx], lat_idx, 4'b0000};
        mem_write_data_c = data_mem[lat_way][lat_idx];
        if (bus.mem_ready) state_next = ALLOCATE;
      end
      ALLOCATE: begin
        mem_read_c    = 1'b1;
        mem_address_c = {lat_tag, lat_idx, 4'b0000};
        if (bus.mem_ready) state_next = COMPARE;
      end
      default: state_next = COMPARE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= COMPARE;
      valid   <= '0;
      dirty   <= '0;
      lru     <= '0;
      read_q  <= '0;
      lat_idx <= '0;
      lat_tag <= '0;
      lat_way <= 1'b0;
    end else begin
      state <= state_next;
      if (state == COMPARE && bus.request) begin
        if (hit) begin
          lru[idx] <= ~hit_way;
          if (bus.read_write) dirty[hit_way][idx] <= 1'b1;
          else                read_q <= hit_word;
        end else begin
          lat_idx <= idx;
          lat_tag <= tag;
          lat_way <= victim;
        end
      end
      if (state == ALLOCATE && bus.mem_ready) begin
        valid[lat_way][lat_idx] <= 1'b1;
        dirty[lat_way][lat_idx] <= 1'b0;
      end
    end
  end

  // Tag and data arrays carry no reset; validity alone decides whether they are meaningful.
  always_ff @(posedge clock) begin
    if (state == COMPARE && bus.request && hit && bus.read_write)
      data_mem[hit_way][idx][{word, 5'd0} +: 32] <= bus.write_data;
    if (state == ALLOCATE && bus.mem_ready) begin
      tag_mem[lat_way][lat_idx]  <= lat_tag;
      data_mem[lat_way][lat_idx] <= bus.mem_read_data;
    end
  end

  assign bus.hit_miss       = hit_miss_c;
  assign bus.read_data      = (hit_miss_c && !bus.read_write) ? hit_word : read_q;
  assign bus.mem_read       = mem_read_c;
  assign bus.mem_write      = mem_write_c;
  assign bus.mem_address    = mem_address_c;
  assign bus.mem_write_data = mem_write_data_c;
  assign debug_state        = state;
endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench for cache_controller: CPU driver tasks, a behavioural memory responder,
// a reference word model and an expected-read queue.
module tb_cache_controller;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [1:0] debug_state;

  always #5 clock = ~clock;

  cache_if #(.ADDR_W(14)) bus ();

  cache_controller #(.ADDR_W(14), .INDEX_W(2)) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus),
    .debug_state (debug_state)
  );

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] ref_word[int];
  logic [127:0] mem_model[int];

  int resp_delay = 3;
  int resp_cnt = 0;
  int rd_cnt = 0, wr_cnt = 0, both_cnt = 0;
  logic resp_ready = 1'b0, spurious_ready = 1'b0;
  logic [127:0] rd_block = '0;
  logic [13:0] last_rd_addr = '0, last_wr_addr = '0;
  logic [127:0] last_wr_data = '0;

  assign bus.mem_ready     = resp_ready | spurious_ready;
  assign bus.mem_read_data = rd_block;

  function automatic logic [127:0] init_block(input logic [13:0] a);
    if (a == 14'h0A0) return {32'h33333333, 32'h22222222, 32'h11111111, 32'h10101010};
    return {16'hB003, 2'b00, a, 16'hB002, 2'b00, a, 16'hB001, 2'b00, a, 16'hB000, 2'b00, a};
  endfunction

  function automatic logic [31:0] expected_word(input logic [13:0] a);
    logic [127:0] b;
    int key;
    key = int'({a[13:2], 2'b00});
    if (ref_word.exists(key)) return ref_word[key];
    b = init_block({a[13:4], 4'b0000});
    return b[int'(a[3:2]) * 32 +: 32];
  endfunction

  // Memory responder: answers each strobe after resp_delay falling edges, one-cycle mem_ready.
  always @(negedge clock) begin
    if (reset) begin
      resp_ready = 1'b0;
      resp_cnt = 0;
    end else if (resp_ready) begin
      resp_ready = 1'b0;
    end else if (bus.mem_read || bus.mem_write) begin
      if (bus.mem_read && bus.mem_write) both_cnt++;
      resp_cnt++;
      if (resp_cnt >= resp_delay) begin
        resp_cnt = 0;
        resp_ready = 1'b1;
        if (bus.mem_write) begin
          wr_cnt++;
          last_wr_addr = bus.mem_address;
          last_wr_data = bus.mem_write_data;
          mem_model[int'(bus.mem_address)] = bus.mem_write_data;
        end else begin
          rd_cnt++;
          last_rd_addr = bus.mem_address;
          rd_block = mem_model.exists(int'(bus.mem_address)) ?
                     mem_model[int'(bus.mem_address)] : init_block(bus.mem_address);
        end
      end
    end else begin
      resp_cnt = 0;
    end
  end

  // Called just after a falling edge; returns the number of cycles spent before completion.
  task automatic access(input logic rw, input logic [13:0] a, input logic [31:0] wd,
                        output int cycles);
    logic done;
    logic [31:0] exp_v;
    bus.request = 1'b1;
    bus.read_write = rw;
    bus.address = a;
    bus.write_data = wd;
    if (!rw) exp_q.push_back(expected_word(a));
    cycles = 0;
    done = 1'b0;
    while (!done && cycles < 200) begin
      #1;
      if (bus.hit_miss) done = 1'b1;
      else begin
        @(negedge clock);
        cycles++;
      end
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL access_timeout addr=%h got no hit_miss, required completion", a);
      if (!rw) void'(exp_q.pop_front());
    end else if (!rw) begin
      exp_v = exp_q.pop_front();
      checks++;
      if (bus.read_data !== exp_v) begin
        failures++;
        $display("FAIL read_data addr=%h got=%h exp=%h", a, bus.read_data, exp_v);
      end
    end else begin
      ref_word[int'({a[13:2], 2'b00})] = wd;
    end
    @(negedge clock);
    bus.request = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if (bus.hit_miss !== 1'b0 || bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) begin
      failures++;
      $display("FAIL reset_strobes got hm=%b rd=%b wr=%b exp 0 0 0",
               bus.hit_miss, bus.mem_read, bus.mem_write);
    end
    checks++;
    if (bus.mem_address !== 14'h0 || bus.mem_write_data !== 128'h0 || bus.read_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_data got addr=%h wdata=%h rdata=%h exp all 0",
               bus.mem_address, bus.mem_write_data, bus.read_data);
    end
    checks++;
    if (debug_state !== 2'd0) begin
      failures++;
      $display("FAIL reset_state got=%0d exp=0", debug_state);
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_clean_miss;
    int c, r0, w0;
    r0 = rd_cnt; w0 = wr_cnt;
    resp_delay = 3;
    access(1'b0, 14'h0A4, 32'h0, c);
    checks++;
    if (c < 4 || rd_cnt - r0 != 1 || wr_cnt - w0 != 0) begin
      failures++;
      $display("FAIL clean_miss got cycles=%0d reads=%0d writes=%0d exp >=4 1 0", c, rd_cnt - r0, wr_cnt - w0);
    end
    checks++;
    if (last_rd_addr !== 14'h0A0) begin
      failures++;
      $display("FAIL clean_miss_addr got=%h exp=0a0", last_rd_addr);
    end
  endtask

  task automatic test_write_hit;
    int c, r0, w0;
    r0 = rd_cnt; w0 = wr_cnt;
    access(1'b1, 14'h0A4, 32'hAABBCCDD, c);
    checks++;
    if (c != 0) begin
      failures++;
      $display("FAIL write_hit_latency got=%0d exp=0", c);
    end
    access(1'b0, 14'h0A0, 32'h0, c);
    access(1'b0, 14'h0A4, 32'h0, c);
    checks++;
    if (c != 0 || rd_cnt != r0 || wr_cnt != w0) begin
      failures++;
      $display("FAIL read_hit got cycles=%0d mem_ops=%0d exp 0 0", c, (rd_cnt - r0) + (wr_cnt - w0));
    end
  endtask

  task automatic test_second_way;
    int c, r0, w0;
    r0 = rd_cnt; w0 = wr_cnt;
    access(1'b0, 14'h1A4, 32'h0, c);
    checks++;
    if (rd_cnt - r0 != 1 || wr_cnt - w0 != 0 || last_rd_addr !== 14'h1A0) begin
      failures++;
      $display("FAIL second_way got reads=%0d writes=%0d addr=%h exp 1 0 1a0",
               rd_cnt - r0, wr_cnt - w0, last_rd_addr);
    end
    access(1'b0, 14'h0A4, 32'h0, c);
    checks++;
    if (c != 0) begin
      failures++;
      $display("FAIL first_way_kept got cycles=%0d exp=0", c);
    end
  endtask

  task automatic test_dirty_evict;
    int c, r0, w0;
    r0 = rd_cnt; w0 = wr_cnt;
    // 0x0A4 was touched last, so way1 (tag 0x06) is LRU... unless the re-read above flipped it
    access(1'b0, 14'h1A4, 32'h0, c);
    access(1'b0, 14'h2A4, 32'h0, c);
    checks++;
    if (wr_cnt - w0 != 1 || last_wr_addr !== 14'h0A0 || last_wr_data[63:32] !== 32'hAABBCCDD) begin
      failures++;
      $display("FAIL dirty_writeback got writes=%0d addr=%h word1=%h exp 1 0a0 aabbccdd",
               wr_cnt - w0, last_wr_addr, last_wr_data[63:32]);
    end
    checks++;
    if (rd_cnt - r0 != 1 || last_rd_addr !== 14'h2A0) begin
      failures++;
      $display("FAIL dirty_refill got reads=%0d addr=%h exp 1 2a0", rd_cnt - r0, last_rd_addr);
    end
    r0 = rd_cnt; w0 = wr_cnt;
    access(1'b0, 14'h0A4, 32'h0, c);
    checks++;
    if (rd_cnt - r0 != 1 || wr_cnt - w0 != 0 || last_rd_addr !== 14'h0A0) begin
      failures++;
      $display("FAIL clean_evict got reads=%0d writes=%0d addr=%h exp 1 0 0a0",
               rd_cnt - r0, wr_cnt - w0, last_rd_addr);
    end
    access(1'b0, 14'h2A4, 32'h0, c);
    checks++;
    if (c != 0) begin
      failures++;
      $display("FAIL keep_mru got cycles=%0d exp=0", c);
    end
  endtask

  task automatic test_reset_mid_transfer;
    int c, r0, w0, n;
    access(1'b1, 14'h2A4, 32'h5A5A0001, c);
    access(1'b1, 14'h0A4, 32'h5A5A0002, c);
    resp_delay = 30;
    bus.request = 1'b1;
    bus.read_write = 1'b0;
    bus.address = 14'h1A4;
    n = 0;
    #1;
    while (!bus.mem_write && n < 10) begin
      @(negedge clock);
      #1;
      n++;
    end
    checks++;
    if (!bus.mem_write || bus.mem_address !== 14'h2A0) begin
      failures++;
      $display("FAIL wb_start got wr=%b addr=%h exp 1 2a0", bus.mem_write, bus.mem_address);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (bus.mem_write !== 1'b0 || bus.mem_read !== 1'b0 || debug_state !== 2'd0) begin
      failures++;
      $display("FAIL reset_abort got wr=%b rd=%b state=%0d exp 0 0 0",
               bus.mem_write, bus.mem_read, debug_state);
    end
    @(negedge clock);
    bus.request = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    resp_delay = 2;
    @(negedge clock);
    r0 = rd_cnt; w0 = wr_cnt;
    access(1'b0, 14'h1A4, 32'h0, c);
    checks++;
    if (c == 0 || rd_cnt - r0 != 1 || wr_cnt - w0 != 0) begin
      failures++;
      $display("FAIL post_reset_miss got cycles=%0d reads=%0d writes=%0d exp >0 1 0",
               c, rd_cnt - r0, wr_cnt - w0);
    end
  endtask

  task automatic test_spurious_ready;
    int c, r0, w0;
    r0 = rd_cnt; w0 = wr_cnt;
    bus.request = 1'b0;
    spurious_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      #1;
      checks++;
      if (bus.mem_read || bus.mem_write || bus.hit_miss || debug_state !== 2'd0) begin
        failures++;
        $display("FAIL spurious_ready cycle=%0d got rd=%b wr=%b hm=%b state=%0d exp 0 0 0 0",
                 i, bus.mem_read, bus.mem_write, bus.hit_miss, debug_state);
      end
    end
    spurious_ready = 1'b0;
    @(negedge clock);
    access(1'b0, 14'h1A4, 32'h0, c);
    checks++;
    if (c != 0 || rd_cnt != r0 || wr_cnt != w0) begin
      failures++;
      $display("FAIL after_spurious_hit got cycles=%0d mem_ops=%0d exp 0 0", c, (rd_cnt - r0) + (wr_cnt - w0));
    end
  endtask

  task automatic test_back_to_back;
    int c;
    logic [7:0] tags [3];
    logic [13:0] a;
    tags[0] = 8'h00; tags[1] = 8'h05; tags[2] = 8'h09;
    for (int i = 0; i < 40; i++) begin
      resp_delay = $urandom_range(1, 4);
      a = {tags[$urandom_range(0, 2)], 2'b01, 2'($urandom_range(0, 3)), 2'b00};
      access(1'($urandom_range(0, 1)), a, $urandom, c);
    end
    checks++;
    if (exp_q.size() != 0 || both_cnt != 0) begin
      failures++;
      $display("FAIL b2b_integrity got pending=%0d overlaps=%0d exp 0 0", exp_q.size(), both_cnt);
    end
  endtask

  initial begin
    bus.request = 1'b0;
    bus.read_write = 1'b0;
    bus.address = '0;
    bus.write_data = '0;
    @(negedge clock);
    test_reset;
    test_clean_miss;
    test_write_hit;
    test_second_way;
    test_dirty_evict;
    test_reset_mid_transfer;
    test_spurious_ready;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no end of test, required completion");
    $fatal(1, "watchdog");
  end
endmodule
